// File: rtl/vga_frame_gen.sv
// VGA frame generator: fixed raster timing fed by a valid-qualified pixel stream.
// FRAME_GEN_PATTERN_EN selects a test gradient instead of magenta as underflow fill.
module vga_frame_gen #(
    parameter int H_ACTIVE = 16,
    parameter int V_ACTIVE = 16,
    parameter int H_BLANK  = 8,
    parameter int V_BLANK  = 4
) (
    input  logic        vga_clk,
    input  logic        rst,
    input  logic        en,
    input  logic        pix_valid,
    input  logic        pix_sof,
    input  logic [23:0] pix_data,
    output logic        pix_ready,
    output logic        vga_vs,
    output logic        vga_hs,
    output logic        vga_de,
    output logic [23:0] vga_data,
    output logic [7:0]  frame_cnt,
    output logic        underflow,
    output logic        sync_err
);

    localparam int H_TOT = H_ACTIVE + H_BLANK;
    localparam int V_TOT = 1 + V_ACTIVE + V_BLANK;
    localparam int HW = ($clog2(H_TOT) < 4) ? 4 : $clog2(H_TOT);
    localparam int VW = ($clog2(V_TOT) < 4) ? 4 : $clog2(V_TOT);

    localparam logic [HW-1:0] H_LAST = HW'(H_TOT - 1);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOT - 1);
    localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] H_SYNC = HW'(H_ACTIVE + 1);
    localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_ONE  = VW'(1);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t          state, state_nx;
    logic [HW-1:0]   h_cnt, h_nx;
    logic [VW-1:0]   v_cnt, v_nx;
    logic            h_last, v_last, frame_end;
    logic            slot, first_slot, accept;
    logic [23:0]     fill;

    always_comb begin
        h_last     = (h_cnt == H_LAST);
        v_last     = (v_cnt == V_LAST);
        frame_end  = (state == RUN) && h_last && v_last;
        slot       = (v_cnt >= V_ONE) && (v_cnt <= V_ACT) && (h_cnt < H_ACT);
        pix_ready  = (state == RUN) && slot;
        accept     = pix_ready && pix_valid;
        first_slot = (v_cnt == V_ONE) && (h_cnt == '0);
    end

`ifdef FRAME_GEN_PATTERN_EN
    logic [3:0] v_row;
    always_comb begin
        v_row = v_cnt[3:0] - 4'd1;
        fill  = {h_cnt[3:0], 4'h0, v_row, 4'h0, frame_cnt};
    end
`else
    always_comb begin
        fill = 24'hFF00FF;
    end
`endif

    // A frame in flight always completes; en is only honoured at its last cycle.
    always_comb begin
        state_nx = state;
        h_nx     = h_cnt;
        v_nx     = v_cnt;
        unique case (state)
            IDLE: begin
                h_nx = '0;
                v_nx = '0;
                if (en) state_nx = RUN;
            end
            RUN: begin
                if (h_last) begin
                    h_nx = '0;
                    if (v_last) begin
                        v_nx = '0;
                        if (!en) state_nx = IDLE;
                    end else begin
                        v_nx = v_cnt + V_ONE;
                    end
                end else begin
                    h_nx = h_cnt + HW'(1);
                end
            end
        endcase
    end

    always_ff @(posedge vga_clk) begin
        if (rst) begin
            state     <= IDLE;
            h_cnt     <= '0;
            v_cnt     <= '0;
            vga_vs    <= 1'b0;
            vga_hs    <= 1'b0;
            vga_de    <= 1'b0;
            vga_data  <= '0;
            frame_cnt <= '0;
            underflow <= 1'b0;
            sync_err  <= 1'b0;
        end else begin
            state     <= state_nx;
            h_cnt     <= h_nx;
            v_cnt     <= v_nx;
            vga_vs    <= (state == RUN) && (v_cnt <= V_ACT);
            vga_hs    <= (state == RUN) && (h_cnt >= H_ACT) && (h_cnt <= H_SYNC);
            vga_de    <= pix_ready;
            if (pix_ready) vga_data <= pix_valid ? pix_data : fill;
            else           vga_data <= '0;
            frame_cnt <= frame_cnt + {7'd0, frame_end};
            if (pix_ready && !pix_valid) underflow <= 1'b1;
            if (accept && (first_slot != pix_sof)) sync_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_vga_frame_gen.sv
// Directed bench for vga_frame_gen: default raster on dut, small raster for wrap.
module tb_vga_frame_gen;

    logic        vga_clk = 1'b0;
    logic        rst, en, pix_valid, pix_sof;
    logic [23:0] pix_data;
    logic        pix_ready, vga_vs, vga_hs, vga_de;
    logic [23:0] vga_data;
    logic [7:0]  frame_cnt;
    logic        underflow, sync_err;

    logic        rst_b, en_b;
    logic        pix_ready_b, vs_b, hs_b, de_b;
    logic [23:0] data_b;
    logic [7:0]  frame_cnt_b;
    logic        underflow_b, sync_err_b;

    int vec = 0;
    int errs = 0;
    int frames_done = 0;

    always #5 vga_clk = ~vga_clk;

    vga_frame_gen dut (
        .vga_clk(vga_clk), .rst(rst), .en(en),
        .pix_valid(pix_valid), .pix_sof(pix_sof), .pix_data(pix_data),
        .pix_ready(pix_ready), .vga_vs(vga_vs), .vga_hs(vga_hs),
        .vga_de(vga_de), .vga_data(vga_data), .frame_cnt(frame_cnt),
        .underflow(underflow), .sync_err(sync_err)
    );

    vga_frame_gen #(
        .H_ACTIVE(4), .V_ACTIVE(2), .H_BLANK(4), .V_BLANK(1)
    ) dut_b (
        .vga_clk(vga_clk), .rst(rst_b), .en(en_b),
        .pix_valid(1'b1), .pix_sof(1'b0), .pix_data(24'h123456),
        .pix_ready(pix_ready_b), .vga_vs(vs_b), .vga_hs(hs_b),
        .vga_de(de_b), .vga_data(data_b), .frame_cnt(frame_cnt_b),
        .underflow(underflow_b), .sync_err(sync_err_b)
    );

    task automatic step;
        @(posedge vga_clk);
        #1;
    endtask

    function automatic logic [23:0] fill_for(input int s, input int fr);
`ifdef FRAME_GEN_PATTERN_EN
        logic [3:0] hh, vv;
        logic [7:0] ff;
        hh = 4'(s % 16);
        vv = 4'(s / 16);
        ff = 8'(fr);
        return {hh, 4'h0, vv, 4'h0, ff};
`else
        return 24'hFF00FF;
`endif
    endfunction

    task automatic chk(input string name, input int act, input int req);
        vec++;
        if (act !== req) begin
            errs++;
            $display("FAIL %s: got %0d, want %0d", name, act, req);
        end
    endtask

    // Runs one 504-cycle frame starting at the sample point of cycle 0.
    task automatic run_frame(input string tag, input int bad,
                             input int sof2, input int drop_at);
        int idx = 0, slot_n = 0, de_n = 0, vs_n = 0;
        int rdy_e = 0, de_e = 0, vs_e = 0, hs_e = 0, dat_e = 0;
        int h, v;
        logic xr, xd, xv, xh;
        logic [23:0] xdat;
        for (int t = 0; t < 504; t++) begin
            h = t % 24;
            v = t / 24;
            if (t == drop_at) en = 1'b0;
            pix_valid = (idx != bad);
            pix_data  = 24'(idx);
            pix_sof   = (idx == 0) || (idx == sof2);
            xr = (v >= 1) && (v <= 16) && (h < 16);
            if (pix_ready !== xr) rdy_e++;
            if (pix_ready) idx++;
            step;
            xd = xr;
            xv = (v <= 16);
            xh = (h == 16) || (h == 17);
            if (vga_de !== xd) de_e++;
            if (vga_vs !== xv) vs_e++;
            if (vga_hs !== xh) hs_e++;
            if (vga_de === 1'b1) de_n++;
            if (vga_vs === 1'b1) vs_n++;
            if (xd) begin
                xdat = (slot_n == bad) ? fill_for(slot_n, frames_done)
                                       : 24'(slot_n);
                if (vga_data !== xdat) dat_e++;
                slot_n++;
            end else if (vga_data !== 24'h0) begin
                dat_e++;
            end
        end
        chk({tag, ".ready_bad_cycles"}, rdy_e, 0);
        chk({tag, ".de_bad_cycles"}, de_e, 0);
        chk({tag, ".vs_bad_cycles"}, vs_e, 0);
        chk({tag, ".hs_bad_cycles"}, hs_e, 0);
        chk({tag, ".data_bad_cycles"}, dat_e, 0);
        chk({tag, ".de_pulses"}, de_n, 256);
        chk({tag, ".vs_cycles"}, vs_n, 17 * 24);
        frames_done++;
        chk({tag, ".frame_cnt"}, int'(frame_cnt), frames_done % 256);
    endtask

    task automatic test_reset;
        rst = 1'b1; en = 1'b1; pix_valid = 1'b1;
        pix_sof = 1'b1; pix_data = 24'hABCDEF;
        step;
        step;
        chk("reset.outputs",
            int'({vga_vs, vga_hs, vga_de, vga_data, underflow, sync_err, pix_ready}), 0);
        chk("reset.frame_cnt", int'(frame_cnt), 0);
        rst = 1'b0;
        step;
        chk("reset.vs_first_run_cycle", int'(vga_vs), 0);
    endtask

    task automatic test_stream;
        run_frame("stream", -1, -1, -1);
        chk("stream.sync_err", int'(sync_err), 0);
        chk("stream.underflow", int'(underflow), 0);
    endtask

    task automatic test_underflow;
        run_frame("underflow", 37, -1, -1);
        chk("underflow.flag", int'(underflow), 1);
        chk("underflow.sync_err", int'(sync_err), 0);
    endtask

    task automatic test_sof;
        run_frame("sof", -1, 5, -1);
        chk("sof.sync_err", int'(sync_err), 1);
    endtask

    task automatic test_en_drop;
        int act = 0;
        run_frame("en_drop", -1, -1, 100);
        for (int i = 0; i < 40; i++) begin
            step;
            if ({vga_vs, vga_hs, vga_de, pix_ready} !== 4'b0) act++;
            if (vga_data !== 24'h0) act++;
        end
        chk("en_drop.idle_activity", act, 0);
        chk("en_drop.frame_cnt_held", int'(frame_cnt), 4);
        chk("en_drop.sticky", int'({underflow, sync_err}), 3);
    endtask

    task automatic test_rst_mid;
        int idx = 0;
        en = 1'b1;
        step;
        for (int t = 0; t < 200; t++) begin
            pix_valid = 1'b1;
            pix_data  = 24'(idx);
            pix_sof   = (idx == 0);
            if (pix_ready) idx++;
            step;
        end
        chk("rst_mid.de_before", int'(vga_de), 1);
        rst = 1'b1;
        step;
        chk("rst_mid.outputs",
            int'({vga_vs, vga_hs, vga_de, vga_data, underflow, sync_err, pix_ready}), 0);
        chk("rst_mid.frame_cnt", int'(frame_cnt), 0);
        rst = 1'b0;
        step;
        chk("rst_mid.vs_at_start", int'(vga_vs), 0);
        step;
        chk("rst_mid.vs_rise", int'(vga_vs), 1);
        chk("rst_mid.de_on_vs_rise", int'(vga_de), 0);
        en = 1'b0;
    endtask

    task automatic test_wrap;
        rst_b = 1'b1; en_b = 1'b0;
        step;
        rst_b = 1'b0; en_b = 1'b1;
        step;
        repeat (255 * 32) step;
        chk("wrap.frame_cnt_255", int'(frame_cnt_b), 255);
        repeat (32) step;
        chk("wrap.frame_cnt_0", int'(frame_cnt_b), 0);
        chk("wrap.flags", int'({underflow_b, sync_err_b}), 1);
    endtask

    initial begin
        rst_b = 1'b1; en_b = 1'b0;
        test_reset;
        test_stream;
        test_underflow;
        test_sof;
        test_en_drop;
        test_rst_mid;
        test_wrap;
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule

// File: doc/vga_frame_gen.md
VGA_FRAME_GEN -- requirements
Module: vga_frame_gen

Interface
REQ-001 Parameters SHALL be one per line:
- H_ACTIVE, 16, active pixels per line.
- V_ACTIVE, 16, active lines per frame.
- H_BLANK, 8, blank cycles per line.
- V_BLANK, 4, blank lines per frame.
REQ-002 Ports SHALL be exactly:
- vga_clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous active-high reset.
- en  in  1  run enable.
- pix_valid  in  1  upstream pixel valid.
- pix_sof  in  1  marks the first pixel of a frame.
- pix_data  in  24  RGB, R in [23:16].
- pix_ready  out  1  pixel accept strobe.
- vga_vs  out  1  frame envelope.
- vga_hs  out  1  line sync.
- vga_de  out  1  data enable.
- vga_data  out  24  pixel.
- frame_cnt  out  8  completed frames.
- underflow  out  1  sticky starvation flag.
- sync_err  out  1  sticky SOF misalignment flag.

Function
REQ-003 Line length SHALL be H_ACTIVE+H_BLANK cycles; h_cnt SHALL count 0..23 at defaults.
REQ-004 Frame length SHALL be 1+V_ACTIVE+V_BLANK lines; v_cnt SHALL count 0..20 at defaults, for 504 cycles per frame.
- Line 0 is the lead-in line.
- Lines 1..V_ACTIVE are active.
- The remaining lines are blank.
REQ-005 The state machine SHALL have two states, IDLE and RUN.
- IDLE->RUN when en=1; counters start at h=0, v=0.
- RUN->IDLE only at the end of the frame where en=0 was sampled on the last cycle; en dropping mid-frame always completes the frame.
REQ-006 pix_ready SHALL be combinational and equal to 1 exactly when state=RUN, v_cnt is in 1..V_ACTIVE and h_cnt<H_ACTIVE.
REQ-007 An active slot SHALL consume the pixel when pix_valid=1; the pixel SHALL appear on vga_data with vga_de=1 on the next cycle (latency 1).
REQ-008 If pix_valid=0 in an active slot:
- vga_de SHALL still be 1 next cycle.
- vga_data SHALL carry the fill colour.
- underflow SHALL set.
- The pixel grid SHALL never stall.
REQ-009 vga_vs SHALL be registered and equal to 1 for lines 0..V_ACTIVE of a RUN frame, otherwise 0.
- Its rising edge SHALL therefore precede the first vga_de by one full line.
- vga_de SHALL never be 1 on the vs rising-edge cycle.
REQ-010 vga_hs SHALL be registered and equal to 1 for h_cnt in H_ACTIVE..H_ACTIVE+1 on every line in RUN.
REQ-011 All vga_* outputs SHALL be aligned to the same one-cycle pipeline delay from the counters.
REQ-012 frame_cnt SHALL increment on the last cycle of each RUN frame and wrap 255->0.
REQ-013 sync_err SHALL set on either condition:
- an accepted pixel with pix_sof=1 that is not the first active slot of the frame;
- an accepted first-slot pixel with pix_sof=0.
The pixel SHALL still be displayed in both cases.
REQ-014 In IDLE:
- vga_vs, vga_hs and vga_de SHALL be 0.
- vga_data SHALL hold 0.
- pix_ready SHALL be 0.
REQ-015 Sticky flags SHALL clear only on rst.

Reset
REQ-016 rst=1 at a rising edge SHALL force:
- state=IDLE, h_cnt=0, v_cnt=0;
- all outputs 0, including frame_cnt=0, underflow=0 and sync_err=0.
REQ-017 rst SHALL take priority over en and pix_valid.
REQ-018 rst asserted mid-frame SHALL abort the frame immediately, with no further vga_de pulses.

Configuration
REQ-019 The macro FRAME_GEN_PATTERN_EN SHALL select the fill colour.
- Defined: fill colour = {h_cnt[3:0],4'h0, v_cnt[3:0]-1,4'h0, frame_cnt}, a test gradient.
- Undefined: fill colour = 24'hFF00FF.
- Underflow flagging SHALL be identical in both builds.

Verification
REQ-020 The bench SHALL cover these scenarios:
- Reset then en=1 with an always-valid source supplying pixels 0..255 (sof on pixel 0) -> 256 vga_de cycles per frame, 16 per line, data 0..255 in order, vs high for 17 lines, frame_cnt=1 after 504 cycles, sync_err=0, underflow=0.
- pix_valid=0 for pixel 37 only -> vga_de=1 for that slot with data 24'hFF00FF (macro undefined), underflow=1, following pixels unshifted.
- pix_sof=1 on pixel 5 -> sync_err=1, frame timing unchanged.
- en dropped at cycle 100 of a frame -> frame completes (504 cycles, 256 de pulses), then IDLE with all outputs 0.
- rst pulsed at cycle 200 -> next cycle all outputs 0, frame_cnt=0; after release with en=1, vs rises 1 cycle later.
- Run 256 frames -> frame_cnt wraps 255->0.
